rb_stream_ctrl: RTL and testbench

//  Streaming controller wrapped around the row-buffer BRAM (simple_bram); sits between the pixel source and the window builder.

---
 rtl/rb_pkg.sv | 39 +++
 rtl/rb_lane_rotate.sv | 32 +++
 rtl/rb_stream_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_rb_stream_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared sizing helpers, FSM encoding and lane mapping for the row-buffer stream controller
package rb_pkg;

   localparam int DEF_PIXEL_BITS   = 8;
   localparam int DEF_IMAGE_WIDTH  = 512;
   localparam int DEF_IMAGE_HEIGHT = 512;
   localparam int DEF_KERNEL_SIZE  = 5;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } rb_state_t;

   // Number of row buffers for a given maximum kernel height.
   function automatic int rb_count(input int kernel_size);
      return kernel_size - 1;
   endfunction

   // Width of an index that selects one row buffer; never narrower than 1 bit.
   function automatic int rb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // BRAM write address width: rb*IMAGE_WIDTH + x.
   function automatic int rb_waddr_w(input int kernel_size, input int image_width);
      return $clog2(rb_count(kernel_size) * image_width);
   endfunction

   // BRAM read address width: column x only.
   function automatic int rb_raddr_w(input int image_width);
      return $clog2(image_width);
   endfunction

   // Buffer holding row y-k while row y is written into buffer wr_rb.
   function automatic int rb_lane_idx(input int wr_rb, input int k, input int n);
      return (wr_rb + n - (k % n)) % n;
   endfunction

endpackage

// File: rtl/rb_lane_rotate.sv
// rtl/rb_lane_rotate.sv - reorders BRAM read lanes into oldest-row-on-top column order and masks unused lanes
module rb_lane_rotate
   import rb_pkg::*;
#(
   parameter int  PIXEL_BITS  = DEF_PIXEL_BITS,
   parameter int  KERNEL_SIZE = DEF_KERNEL_SIZE,
   localparam int RB_CNT      = rb_count(KERNEL_SIZE),
   localparam int RBW         = rb_idx_w(RB_CNT)
) (
   input  logic [PIXEL_BITS-1:0]             live_pix,
   input  logic [PIXEL_BITS*RB_CNT-1:0]      rdata,
   input  logic [RBW-1:0]                    wr_rb,
   input  logic                              short_kernel,
   output logic [PIXEL_BITS*KERNEL_SIZE-1:0] col
);

   int k_eff;

   // Lane 0 is the live pixel; lane k comes from the buffer written k rows ago, zero beyond K_eff.
   always_comb begin
      k_eff = short_kernel ? 3 : KERNEL_SIZE;
      col   = '0;
      col[PIXEL_BITS-1:0] = live_pix;
      for (int k = 1; k < KERNEL_SIZE; k++) begin
         if (k < k_eff) begin
            col[k*PIXEL_BITS +: PIXEL_BITS] =
               rdata[rb_lane_idx(int'(wr_rb), k, RB_CNT)*PIXEL_BITS +: PIXEL_BITS];
         end
      end
   end

endmodule

// File: rtl/rb_stream_ctrl.sv
// rtl/rb_stream_ctrl.sv - raster stream to KERNEL_SIZE-tall column controller over circular row buffers (optional RB_STREAM_STATS_EN)
module rb_stream_ctrl
   import rb_pkg::*;
#(
   parameter int  PIXEL_BITS   = DEF_PIXEL_BITS,
   parameter int  IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int  IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int  KERNEL_SIZE  = DEF_KERNEL_SIZE,
   localparam int RB_CNT       = rb_count(KERNEL_SIZE),
   localparam int RBW          = rb_idx_w(RB_CNT),
   localparam int AW           = rb_waddr_w(KERNEL_SIZE, IMAGE_WIDTH),
   localparam int XW           = rb_raddr_w(IMAGE_WIDTH),
   localparam int YW           = $clog2(IMAGE_HEIGHT)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              kernel_size,
   input  logic                              pix_valid,
   output logic                              pix_ready,
   input  logic [PIXEL_BITS-1:0]             pix_data,
   output logic                              bram_we,
   output logic [AW-1:0]                     bram_waddr,
   output logic [PIXEL_BITS-1:0]             bram_wdata,
   output logic                              bram_re,
   output logic [XW-1:0]                     bram_raddr,
   input  logic [PIXEL_BITS*RB_CNT-1:0]      bram_rdata,
   output logic                              col_valid,
   input  logic                              col_ready,
   output logic [PIXEL_BITS*KERNEL_SIZE-1:0] col_data,
   output logic [XW-1:0]                     col_x,
   output logic                              col_last,
   output logic                              frame_done
`ifdef RB_STREAM_STATS_EN
   ,
   output logic [31:0]                       stall_cnt,
   output logic [15:0]                       frame_cnt
`endif
);

   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   logic [RBW-1:0] wr_rb;
   logic           k_short;
   rb_state_t      state, state_nxt;

   logic                   s1_valid;
   logic                   s1_fresh;
   logic                   s1_emit;
   logic                   s1_row_last;
   logic                   s1_short;
   logic [PIXEL_BITS-1:0]  s1_pix;
   logic [XW-1:0]          s1_x;
   logic [RBW-1:0]         s1_rb;

   logic [PIXEL_BITS*RB_CNT-1:0]      hold_rdata;
   logic [PIXEL_BITS*RB_CNT-1:0]      rdata_sel;
   logic [PIXEL_BITS*KERNEL_SIZE-1:0] rot_col;
   logic                              out_row_last;

   logic           out_free;
   logic           accept;
   logic           x_last;
   logic           y_last;
   logic [YW-1:0]  fill_last_row;

   assign out_free      = !col_valid | col_ready;
   assign pix_ready     = !rst & (!s1_valid | out_free);
   assign accept        = pix_valid & pix_ready;
   assign x_last        = (x == XW'(IMAGE_WIDTH - 1));
   assign y_last        = (y == YW'(IMAGE_HEIGHT - 1));
   assign fill_last_row = k_short ? YW'(1) : YW'(KERNEL_SIZE - 2);

   // Read the whole column of buffered rows in the accept cycle; write the new pixel one cycle later.
   assign bram_re    = accept;
   assign bram_raddr = accept ? x : '0;
   assign bram_we    = s1_fresh;
   assign bram_waddr = s1_fresh ? (AW'(s1_rb) * AW'(IMAGE_WIDTH) + AW'(s1_x)) : '0;
   assign bram_wdata = s1_fresh ? s1_pix : '0;

   // Raster position, circular buffer pointer and per-frame kernel height selection.
   always_ff @(posedge clk) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         wr_rb   <= '0;
         k_short <= 1'b0;
      end else if (accept) begin
         if (x == '0 && y == '0) begin
            k_short <= kernel_size;
         end
         if (x_last) begin
            x <= '0;
            if (y_last) begin
               y     <= '0;
               wr_rb <= '0;
            end else begin
               y     <= y + 1'b1;
               wr_rb <= (wr_rb == RBW'(RB_CNT - 1)) ? '0 : wr_rb + 1'b1;
            end
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // FILL until the row before the first full window has been accepted; RUN until the frame's last pixel.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (accept && x_last && y == fill_last_row) state_nxt = RUN;
         RUN:  if (accept && x_last && y_last)             state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // S1 stage: one pixel in flight, waiting for its BRAM read data and a free output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_fresh    <= 1'b0;
         s1_emit     <= 1'b0;
         s1_row_last <= 1'b0;
         s1_short    <= 1'b0;
         s1_pix      <= '0;
         s1_x        <= '0;
         s1_rb       <= '0;
      end else begin
         s1_fresh <= accept;
         if (accept) begin
            s1_valid    <= 1'b1;
            s1_emit     <= (state == RUN);
            s1_row_last <= y_last;
            s1_short    <= k_short;
            s1_pix      <= pix_data;
            s1_x        <= x;
            s1_rb       <= wr_rb;
         end else if (out_free) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Read data is only on the BRAM port for one cycle, so keep it if the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_rdata <= '0;
      end else if (s1_fresh && !out_free) begin
         hold_rdata <= bram_rdata;
      end
   end

   assign rdata_sel = s1_fresh ? bram_rdata : hold_rdata;

   rb_lane_rotate #(
      .PIXEL_BITS  (PIXEL_BITS),
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_rotate (
      .live_pix     (s1_pix),
      .rdata        (rdata_sel),
      .wr_rb        (s1_rb),
      .short_kernel (s1_short),
      .col          (rot_col)
   );

   // Output register: load an emitting S1 pixel whenever the slot is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_valid    <= 1'b0;
         col_data     <= '0;
         col_x        <= '0;
         col_last     <= 1'b0;
         out_row_last <= 1'b0;
      end else if (out_free) begin
         if (s1_valid && s1_emit) begin
            col_valid    <= 1'b1;
            col_data     <= rot_col;
            col_x        <= s1_x;
            col_last     <= (s1_x == XW'(IMAGE_WIDTH - 1));
            out_row_last <= s1_row_last;
         end else begin
            col_valid <= 1'b0;
         end
      end
   end

   // Pulse once the last column of the last row has been taken downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= col_valid & col_ready & col_last & out_row_last;
      end
   end

`ifdef RB_STREAM_STATS_EN
   // Back-pressure cycle count and saturating frame count.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         frame_cnt <= '0;
      end else begin
         if (col_valid && !col_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (frame_done && frame_cnt != 16'hFFFF) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rb_stream_ctrl.sv
// tb/tb_rb_stream_ctrl.sv - table-driven scoreboard bench for rb_stream_ctrl with a behavioural row-buffer BRAM
module tb_rb_stream_ctrl;

   localparam int PB = 8;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int KS = 5;
   localparam int RB = KS - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          kernel_size = 1'b0;
   logic          pix_valid = 1'b1;
   logic          pix_ready;
   logic [PB-1:0] pix_data = '0;
   logic          bram_we;
   logic [4:0]    bram_waddr;
   logic [PB-1:0] bram_wdata;
   logic          bram_re;
   logic [2:0]    bram_raddr;
   logic [PB*RB-1:0] bram_rdata;
   logic          col_valid;
   logic          col_ready = 1'b1;
   logic [PB*KS-1:0] col_data;
   logic [2:0]    col_x;
   logic          col_last;
   logic          frame_done;
`ifdef RB_STREAM_STATS_EN
   logic [31:0]   stall_cnt;
   logic [15:0]   frame_cnt;
`endif

   always #5 clk = ~clk;

   rb_stream_ctrl #(
      .PIXEL_BITS   (PB),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .KERNEL_SIZE  (KS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .kernel_size (kernel_size),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .bram_we     (bram_we),
      .bram_waddr  (bram_waddr),
      .bram_wdata  (bram_wdata),
      .bram_re     (bram_re),
      .bram_raddr  (bram_raddr),
      .bram_rdata  (bram_rdata),
      .col_valid   (col_valid),
      .col_ready   (col_ready),
      .col_data    (col_data),
      .col_x       (col_x),
      .col_last    (col_last),
      .frame_done  (frame_done)
`ifdef RB_STREAM_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .frame_cnt   (frame_cnt)
`endif
   );

   // Behavioural BRAM: one write port, all buffers read at column x with 1-cycle latency.
   logic [PB-1:0] mem [RB][W];
   always @(posedge clk) begin
      if (bram_re) begin
         for (int j = 0; j < RB; j++) bram_rdata[j*PB +: PB] <= mem[j][bram_raddr];
      end
      if (bram_we) mem[bram_waddr / W][bram_waddr % W] <= bram_wdata;
   end

   typedef struct {
      logic [PB*KS-1:0] data;
      logic [2:0]       x;
      logic             last;
   } col_t;

   typedef struct {
      bit short_k;
      bit toggle;
      bit gaps;
      int stall_at;
      int stall_len;
      int frames;
      int exp_cols;
      int exp_fd;
      int exp_stall;
   } vec_t;

   col_t sb[$];
   vec_t vecs[6];

   int checks = 0;
   int passed = 0;
   int gx, gy, frames_left, model_keff;
   int cols_seen, fd_seen, stall_left;
   bit stall_done;
   logic [PB*KS-1:0] stall_ref;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_outputs();
      check("reset_ctrl", {pix_ready, bram_re, bram_we, col_valid, frame_done, col_last}, '0);
      check("reset_data", {col_data, col_x, bram_waddr, bram_wdata, bram_raddr}, '0);
   endtask

   // Expected column from the raster pattern pixel(x,y) = y*W + x.
   task automatic push_expected(input int x, input int y);
      col_t c;
      if (y >= model_keff - 1) begin
         c.data = '0;
         for (int k = 0; k < KS; k++) begin
            if (k < model_keff) c.data[k*PB +: PB] = PB'((y - k) * W + x);
         end
         c.x    = 3'(x);
         c.last = (x == W - 1);
         sb.push_back(c);
      end
   endtask

   task automatic step(input vec_t v);
      col_t e;
      @(negedge clk);
      if (v.stall_len > 0 && !stall_done && cols_seen == v.stall_at + 1) begin
         stall_left = v.stall_len;
         stall_done = 1'b1;
      end
      col_ready = (stall_left == 0);
      if (frames_left > 0) begin
         pix_valid = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         pix_data  = PB'(gy * W + gx);
         if (gx == 0 && gy == 0) kernel_size = v.short_k;
         else                    kernel_size = v.toggle ? !v.short_k : v.short_k;
      end else begin
         pix_valid = 1'b0;
      end
      #1;
      if (col_valid && !col_ready) begin
         if (stall_left == v.stall_len) stall_ref = col_data;
         else check("stall_hold", col_data, stall_ref);
         if (!v.gaps) check("stall_pix_ready", pix_ready, 1'b0);
      end
      if (col_valid && col_ready) begin
         check("col_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("col", {col_last, col_x, col_data}, {e.last, e.x, e.data});
         end
         cols_seen++;
      end
      if (pix_valid && pix_ready) begin
         if (gx == 0 && gy == 0) model_keff = kernel_size ? 3 : KS;
         push_expected(gx, gy);
         if (gx == W - 1) begin
            gx = 0;
            if (gy == H - 1) begin
               gy = 0;
               frames_left--;
            end else begin
               gy++;
            end
         end else begin
            gx++;
         end
      end
      if (frame_done) fd_seen++;
      if (stall_left > 0) stall_left--;
   endtask

   task automatic start_stream(input vec_t v);
      sb.delete();
      frames_left = v.frames;
      gx = 0;
      gy = 0;
      model_keff = KS;
      cols_seen = 0;
      fd_seen = 0;
      stall_left = 0;
      stall_done = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input bit do_rst);
      int cyc;
      if (do_rst) begin
         @(negedge clk);
         rst = 1'b1;
         pix_valid = 1'b0;
         col_ready = 1'b1;
         repeat (2) @(negedge clk);
         rst = 1'b0;
      end
      start_stream(v);
      cyc = 0;
      while (!(frames_left == 0 && sb.size() == 0) && cyc < 2000) begin
         step(v);
         cyc++;
      end
      check("drained", (frames_left == 0 && sb.size() == 0), 1'b1);
      repeat (4) step(v);
      check("col_count", cols_seen, v.exp_cols);
      check("frame_done_count", fd_seen, v.exp_fd);
`ifdef RB_STREAM_STATS_EN
      check("stall_cnt", stall_cnt, v.exp_stall);
      check("frame_cnt", frame_cnt, v.exp_fd);
`endif
   endtask

   initial begin
      int cyc;
      //         short toggle gaps stall_at len frames cols fd stall
      vecs[0] = '{1'b0, 1'b0, 1'b0, -1,     0,  1,     16,  1, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, -1,     0,  1,     32,  1, 0};
      vecs[2] = '{1'b0, 1'b0, 1'b0,  3,     5,  1,     16,  1, 5};
      vecs[3] = '{1'b0, 1'b0, 1'b0, -1,     0,  2,     32,  2, 0};
      vecs[4] = '{1'b1, 1'b1, 1'b1, -1,     0,  2,     64,  2, 0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 20,     4,  1,     32,  1, 4};

      // Reset state with a pixel offered: nothing may be accepted or driven.
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs();

      foreach (vecs[i]) run_vec(vecs[i], 1'b1);

      // Reset in the middle of row 3, then a clean frame from scratch.
      @(negedge clk);
      rst = 1'b0;
      start_stream(vecs[0]);
      cyc = 0;
      while (!(gy == 3 && gx == 3) && cyc < 200) begin
         step(vecs[0]);
         cyc++;
      end
      check("reached_row3", {gy[7:0], gx[7:0]}, {8'd3, 8'd3});
      @(negedge clk);
      rst = 1'b1;
      pix_valid = 1'b1;
      col_ready = 1'b1;
      @(negedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      pix_valid = 1'b0;
      run_vec(vecs[0], 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
